// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready request into one APB transfer and returns
// the completer's data and error status through a valid/ready response channel.
module apb_requester #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] out_paddr,
    output logic [31:0] out_pwdata,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [2:0]  out_pprot,
    output logic [3:0]  out_pstrb,
    input  logic        in_pready,
    input  logic        in_pslverr,
    input  logic [31:0] in_prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state_q;
    logic [31:0] wait_q;
    logic [31:0] wait_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [3:0]  strb_q;
    logic [2:0]  prot_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_ready_q;
    logic        psel_q;
    logic        penable_q;
    logic        rsp_valid_q;
    logic        timeout_hit;

    // The timeout fires on the stalled ACCESS cycle that brings the count to TIMEOUT.
    assign wait_d      = wait_q + 32'd1;
    assign timeout_hit = (TIMEOUT != 32'd0) && (wait_d == TIMEOUT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            strb_q      <= '0;
            prot_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        strb_q      <= req_write ? req_wstrb : 4'b0000;
                        prot_q      <= req_prot;
                        req_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        state_q     <= SETUP;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (in_pready) begin
                        err_q       <= in_pslverr;
                        rdata_q     <= write_q ? 32'd0 : in_prdata;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        wait_q      <= wait_d;
                        err_q       <= 1'b1;
                        rdata_q     <= '0;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_paddr   = addr_q;
    assign out_pwdata  = wdata_q;
    assign out_pwrite  = write_q;
    assign out_pprot   = prot_q;
    assign out_pstrb   = strb_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: one task per scenario, inline checks.
module tb_apb_requester;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_write = 1'b0;
    logic [3:0]  req_wstrb = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] out_paddr;
    logic [31:0] out_pwdata;
    logic        out_psel;
    logic        out_penable;
    logic        out_pwrite;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;
    logic        in_pready = 1'b0;
    logic        in_pslverr = 1'b0;
    logic [31:0] in_prdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations captured by the transfer driver
    logic        ob_setup_psel, ob_setup_pen, ob_setup_rr, ob_pwrite, ob_stable;
    logic [31:0] ob_paddr, ob_pwdata;
    logic [3:0]  ob_pstrb;
    logic [2:0]  ob_pprot;
    int          ob_acc;

    apb_requester #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .req_wstrb(req_wstrb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_psel(out_psel),
        .out_penable(out_penable), .out_pwrite(out_pwrite),
        .out_pprot(out_pprot), .out_pstrb(out_pstrb),
        .in_pready(in_pready), .in_pslverr(in_pslverr), .in_prdata(in_prdata)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one request from IDLE and runs it until the ACCESS phase ends.
    // waits < 0 keeps in_pready low forever.
    task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                            input logic [3:0] s, input logic [2:0] p, input int waits,
                            input logic err, input logic [31:0] rd);
        req_addr = a; req_wdata = wd; req_write = w; req_wstrb = s; req_prot = p;
        req_valid = 1'b1; in_pready = 1'b0; in_pslverr = err; in_prdata = rd;
        step();
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_write = ~w;
        req_wstrb = ~s; req_prot = ~p;
        ob_setup_psel = out_psel; ob_setup_pen = out_penable; ob_setup_rr = req_ready;
        ob_paddr = out_paddr; ob_pwdata = out_pwdata; ob_pwrite = out_pwrite;
        ob_pstrb = out_pstrb; ob_pprot = out_pprot;
        ob_acc = 0; ob_stable = 1'b1;
        step();
        while (out_penable === 1'b1 && ob_acc < 40) begin
            ob_acc++;
            if (out_psel !== 1'b1 || out_paddr !== a || out_pwdata !== wd) ob_stable = 1'b0;
            if (waits >= 0 && ob_acc == waits + 1) in_pready = 1'b1;
            step();
        end
        in_pready = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({req_ready, rsp_valid, out_psel, out_penable} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, expected 0000", {req_ready, rsp_valid, out_psel, out_penable});
        end
        n_tests++;
        if ({out_paddr, out_pwdata, rsp_rdata, out_pstrb} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h, expected all 0", out_paddr, out_pwdata, rsp_rdata, out_pstrb);
        end
        step(); step();
        reset = 1'b1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rr_release: got %b, expected 0", req_ready);
        end
        step();
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_rr_rise: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_write();
        in_prdata = 32'h1234_5678;
        run_xfer(32'h2100_0010, 32'hA5A5_1234, 1'b1, 4'hF, 3'b010, 0, 1'b0, 32'h1234_5678);
        n_tests++;
        if ({ob_setup_psel, ob_setup_pen, ob_setup_rr} !== 3'b100) begin
            n_fail++; $display("FAIL wr_setup_ctrl: got %b, expected 100", {ob_setup_psel, ob_setup_pen, ob_setup_rr});
        end
        n_tests++;
        if (ob_paddr !== 32'h2100_0010 || ob_pwdata !== 32'hA5A5_1234) begin
            n_fail++; $display("FAIL wr_setup_addr_data: got %h %h, expected 21000010 a5a51234", ob_paddr, ob_pwdata);
        end
        n_tests++;
        if ({ob_pwrite, ob_pstrb, ob_pprot} !== {1'b1, 4'hF, 3'b010}) begin
            n_fail++; $display("FAIL wr_setup_wr_strb_prot: got %b %h %b, expected 1 f 010", ob_pwrite, ob_pstrb, ob_pprot);
        end
        n_tests++;
        if (ob_acc !== 1 || ob_stable !== 1'b1) begin
            n_fail++; $display("FAIL wr_access: got cycles %0d stable %b, expected 1 1", ob_acc, ob_stable);
        end
        n_tests++;
        if ({rsp_valid, rsp_err, out_psel, out_penable} !== 4'b1000 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wr_resp: got v/e/sel/en %b rdata %h, expected 1000 0", {rsp_valid, rsp_err, out_psel, out_penable}, rsp_rdata);
        end
        finish_rsp();
        n_tests++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL wr_idle: got %b, expected 01", {rsp_valid, req_ready});
        end
        n_tests++;
        if (out_paddr !== 32'h2100_0010 || out_pstrb !== 4'hF || out_pwrite !== 1'b1) begin
            n_fail++; $display("FAIL wr_hold: got %h %h %b, expected 21000010 f 1", out_paddr, out_pstrb, out_pwrite);
        end
    endtask

    // Three wait states; ready arrives on the 4th stalled cycle, which also
    // coincides with the TIMEOUT=4 boundary, so normal completion must win.
    task automatic test_read();
        run_xfer(32'h1000_0004, 32'h7777_7777, 1'b0, 4'hF, 3'b001, 3, 1'b0, 32'hDEAD_BEEF);
        n_tests++;
        if (ob_pstrb !== 4'h0 || ob_pwrite !== 1'b0 || ob_paddr !== 32'h1000_0004) begin
            n_fail++; $display("FAIL rd_setup: got strb %h wr %b addr %h, expected 0 0 10000004", ob_pstrb, ob_pwrite, ob_paddr);
        end
        n_tests++;
        if (ob_acc !== 4 || ob_stable !== 1'b1) begin
            n_fail++; $display("FAIL rd_access: got cycles %0d stable %b, expected 4 1", ob_acc, ob_stable);
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_resp: got v %b e %b rdata %h, expected 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_slverr_hold();
        int bad = 0;
        run_xfer(32'h2000_0100, 32'h0BAD_F00D, 1'b1, 4'h3, 3'b000, 0, 1'b1, 32'h5555_5555);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL err_resp: got v %b e %b rdata %h, expected 1 1 0", rsp_valid, rsp_err, rsp_rdata);
        end
        // Wiggle the APB inputs while the response waits; nothing may change.
        for (int i = 0; i < 5; i++) begin
            in_pready = 1'b1; in_pslverr = 1'b0; in_prdata = 32'hFFFF_0000 + i;
            step();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || out_psel !== 1'b0) bad++;
        end
        in_pready = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL err_hold: got %0d bad cycles, expected 0", bad);
        end
        finish_rsp();
        n_tests++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL err_release: got %b, expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_timeout();
        run_xfer(32'h3000_0008, 32'h0, 1'b0, 4'h0, 3'b100, -1, 1'b0, 32'hCAFE_F00D);
        n_tests++;
        if (ob_acc !== 4) begin
            n_fail++; $display("FAIL to_cycles: got %0d, expected 4", ob_acc);
        end
        n_tests++;
        if ({rsp_valid, rsp_err, out_psel} !== 3'b110 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_resp: got v/e/sel %b rdata %h, expected 110 0", {rsp_valid, rsp_err, out_psel}, rsp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        req_addr = 32'h4000_0000; req_write = 1'b0; req_valid = 1'b1; in_pready = 1'b0;
        step();
        req_valid = 1'b0;
        step(); step();
        n_tests++;
        if ({out_psel, out_penable} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b, expected 11", {out_psel, out_penable});
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({out_psel, out_penable, rsp_valid, req_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_async: got %b, expected 0000", {out_psel, out_penable, rsp_valid, req_ready});
        end
        step();
        reset = 1'b1;
        in_pready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid !== 1'b0 || out_psel !== 1'b0) seen++;
        end
        in_pready = 1'b0;
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_mid_no_rsp: got %0d active cycles, expected 0", seen);
        end
        run_xfer(32'h1000_0020, 32'h0, 1'b0, 4'h0, 3'b000, 1, 1'b0, 32'h0123_4567);
        n_tests++;
        if (ob_acc !== 2 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0123_4567) begin
            n_fail++; $display("FAIL rst_mid_next: got cycles %0d v %b rdata %h, expected 2 1 01234567", ob_acc, rsp_valid, rsp_rdata);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat, exp_pat;
        int nrsp = 0;
        req_addr = 32'h5000_0000; req_wdata = 32'h1111_2222; req_write = 1'b1; req_wstrb = 4'hC;
        req_valid = 1'b1; rsp_ready = 1'b1; in_pready = 1'b1; in_pslverr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            pat[i] = out_psel;
            exp_pat[i] = ((i % 4) < 2);
            if (rsp_valid === 1'b1) nrsp++;
        end
        req_valid = 1'b0; rsp_ready = 1'b0; in_pready = 1'b0;
        n_tests++;
        if (pat !== exp_pat) begin
            n_fail++; $display("FAIL b2b_psel: got %b, expected %b", pat, exp_pat);
        end
        n_tests++;
        if (nrsp != 4) begin
            n_fail++; $display("FAIL b2b_rsp: got %0d, expected 4", nrsp);
        end
        step(); step();
        n_tests++;
        if ({out_psel, req_ready, rsp_valid} !== 3'b010) begin
            n_fail++; $display("FAIL b2b_end: got %b, expected 010", {out_psel, req_ready, rsp_valid});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_slverr_hold();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum ACCESS-phase wait cycles before forced error completion; 0 disables the timeout.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 req_valid/req_ready  input/output  1/1  request handshake.
REQ-005 req_addr/req_wdata  input  32/32  request address and write data.
REQ-006 req_write/req_wstrb/req_prot  input  1/4/3  direction (1 = write), byte strobes, protection.
REQ-007 rsp_valid/rsp_ready  output/input  1/1  response handshake.
REQ-008 rsp_rdata/rsp_err  output  32/1  read data and error flag.
REQ-009 out_paddr/out_pwdata  output  32/32  APB address and write data.
REQ-010 out_psel/out_penable/out_pwrite  output  1/1/1  APB control.
REQ-011 out_pprot/out_pstrb  output  3/4  APB protection and strobes.
REQ-012 in_pready/in_pslverr/in_prdata  input  1/1/32  APB completer response.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
REQ-015 On acceptance, addr, wdata, write, wstrb and prot SHALL be latched and the state SHALL become SETUP; the request inputs are then ignored until the next IDLE.
REQ-016 SETUP: out_psel=1, out_penable=0, latched fields on APB outputs; next state ACCESS unconditionally (exactly one cycle).
REQ-017 ACCESS: out_psel=1, out_penable=1, APB outputs held stable; state holds while in_pready=0.
REQ-018 out_pstrb SHALL equal the latched wstrb for writes and 4'b0000 for reads.
REQ-019 ACCESS with in_pready=1: capture rsp_err=in_pslverr and rsp_rdata=(read ? in_prdata : 0); next state RESP.
REQ-020 A 32-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with in_pready=0; with TIMEOUT>0 and the count equal to TIMEOUT, next state SHALL be RESP with rsp_err=1 and rsp_rdata=0.
REQ-021 in_pready=1 on the same edge the timeout fires SHALL take priority (normal completion).
REQ-022 Outside SETUP/ACCESS: out_psel=0, out_penable=0; out_paddr, out_pwdata, out_pwrite, out_pprot and out_pstrb hold their last values.
REQ-023 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready=1, next state IDLE. rsp_valid SHALL be 0 in all other states.
REQ-024 Minimum latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2 (in_pready=1) -> rsp_valid=1 in cycle N+3; back-to-back throughput one transfer per 4 cycles.
REQ-025 APB inputs SHALL be ignored in IDLE, SETUP and RESP.

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) force IDLE and all outputs to 0, req_ready included; req_ready rises to 1 in the first cycle after release.
REQ-027 Reset during SETUP/ACCESS SHALL abort the transfer without producing a response; out_psel drops asynchronously.
REQ-028 The wait counter and latched request fields SHALL reset to 0.

Verification
REQ-029 Write addr 0x2100_0010, wdata 0xA5A5_1234, wstrb 0xF, completer in_pready=1 in the first ACCESS cycle -> SETUP 1 cycle, ACCESS 1 cycle, pstrb 0xF, rsp_valid 3 cycles after acceptance, rsp_err 0, rsp_rdata 0.
REQ-030 Read addr 0x1000_0004, completer 3 wait states then in_prdata 0xDEAD_BEEF -> ACCESS 4 cycles, pstrb 0x0, rsp_rdata 0xDEAD_BEEF.
REQ-031 Completer returns in_pslverr=1 on a write -> rsp_err=1; rsp_valid held 5 cycles while rsp_ready=0, req_ready=0 throughout.
REQ-032 TIMEOUT=4, in_pready stuck at 0 -> 4 stalled ACCESS cycles, psel drops, rsp_err=1, rsp_rdata 0; in_pready=1 on the 4th stalled cycle -> normal completion.
REQ-033 reset=0 mid-ACCESS -> psel/penable/rsp_valid drop 0 immediately; after release no response is produced, the next request completes normally.
REQ-034 Back-to-back requests with req_valid and rsp_ready held 1 -> one APB transfer per 4 cycles, psel low for exactly 2 cycles between transfers.
